// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: byte lanes and FSM states.
package mem_pkg;

  typedef logic [7:0] byte_t;

  localparam int WORD_BYTES = 4;

  // Lane 0 is the lowest byte address of the word and the most significant
  // byte of the packed value.
  typedef byte_t [0:WORD_BYTES-1] word_lanes_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Cache <-> memory word-request bus.
// The master is the cache side. The slave is the responder.
interface data_mem_responder_if;
  import mem_pkg::*;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  word_lanes_t mem_data_in;
  word_lanes_t mem_data_out;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_error;

  modport master (
    output mem_req, mem_addr, mem_write_en, mem_data_in,
    input  mem_data_out, mem_busy, mem_done, mem_error
  );

  modport slave (
    input  mem_req, mem_addr, mem_write_en, mem_data_in,
    output mem_data_out, mem_busy, mem_done, mem_error
  );
endinterface

// File: rtl/data_mem_responder_mem_bank.sv
// Single-port word array with four byte lanes and synchronous read/write.
// The array contents survive reset. Only the read register is cleared.
module mem_bank
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-3:0] idx,
  input  word_lanes_t          din,
  output word_lanes_t          dout
);

  localparam int DEPTH = 2 ** (ADDR_BITS - 2);

  word_lanes_t mem [DEPTH];

  // Write port: all four lanes are committed together.
  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= din;
  end

  // Read register: updated only by reads, so writes leave it untouched.
  always_ff @(posedge clk) begin
    if (reset)          dout <= '0;
    else if (en && !we) dout <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder for the data-cache refill/write-back port.
// A request is latched in IDLE. The access runs after LATENCY cycles, and
// completion is signalled with a one-cycle done pulse.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 4
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  mem_state_t  state;
  logic [7:0]  cnt;
  logic [31:0] req_addr;
  logic        req_we;
  word_lanes_t req_data;
  logic        rd_zero;
  logic        busy, done, error;
  logic        err, access, bank_en;
  word_lanes_t bank_q;

  // Misaligned, or outside the decoded window. The shift form also covers ADDR_BITS=32.
  assign err     = (req_addr[1:0] != 2'b00) || ((req_addr >> ADDR_BITS) != 32'd0);
  assign access  = (state == WAIT) && (cnt == 8'd0);
  // The reset gate drops a pending access that coincides with reset.
  assign bank_en = access && !err && !reset;

  mem_bank #(.ADDR_BITS(ADDR_BITS)) u_bank (
    .clk   (clk),
    .reset (reset),
    .en    (bank_en),
    .we    (req_we),
    .idx   (req_addr[ADDR_BITS-1:2]),
    .din   (req_data),
    .dout  (bank_q)
  );

  // A failed read shows zeros, and a failed write leaves the last read data visible.
  assign bus.mem_data_out = rd_zero ? '0 : bank_q;
  assign bus.mem_busy     = busy;
  assign bus.mem_done     = done;
  assign bus.mem_error    = error;

  // Request FSM: accept in IDLE, count down in WAIT, pulse done in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      rd_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            req_addr <= bus.mem_addr;
            req_we   <= bus.mem_write_en;
            req_data <= bus.mem_data_in;
            cnt      <= 8'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= RESP;
            done  <= 1'b1;
            error <= err;
            if (!req_we) rd_zero <= err;
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
